// File: rtl/branch_recv_ctrl.sv
// Branch-result consumer for the warp scheduler: owns the per-warp PC table and
// in-flight branch counters, and drives a one-entry registered flush/redirect.
module branch_recv_ctrl #(
  parameter int NUM_WARP   = 8,
  parameter int DEPTH_WARP = 3,
  parameter int CNT_W      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_valid_i,
  input  logic [DEPTH_WARP-1:0]    start_wid_i,
  input  logic [31:0]              start_pc_i,
  input  logic                     fetch_fire_i,
  input  logic [DEPTH_WARP-1:0]    fetch_wid_i,
  input  logic                     br_issue_i,
  input  logic [DEPTH_WARP-1:0]    br_issue_wid_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DEPTH_WARP-1:0]    in_wid_i,
  input  logic                     in_jump_i,
  input  logic [31:0]              in_new_pc_i,
  output logic                     flush_valid_o,
  input  logic                     flush_ready_i,
  output logic [DEPTH_WARP-1:0]    flush_wid_o,
  output logic [31:0]              flush_pc_o,
  output logic [NUM_WARP*32-1:0]   pc_o,
  output logic [NUM_WARP-1:0]      br_block_o,
  output logic                     cnt_err_o
);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]           pc_q  [NUM_WARP];
  logic [31:0]           pc_d  [NUM_WARP];
  cnt_t                  cnt_q [NUM_WARP];
  cnt_t                  cnt_d [NUM_WARP];
  logic                  flush_valid_q, flush_valid_d;
  logic [DEPTH_WARP-1:0] flush_wid_q,   flush_wid_d;
  logic [31:0]           flush_pc_q,    flush_pc_d;
  logic                  cnt_err_q,     cnt_err_d;

  logic                  accept;
  logic                  taken;
  logic [NUM_WARP-1:0]   start_hit;
  logic [NUM_WARP-1:0]   inc_hit;
  logic [NUM_WARP-1:0]   dec_hit;
  logic [NUM_WARP-1:0]   fetch_hit;

  // Ready depends only on the flush register, so in_valid_i never reaches an output.
  always_comb begin : handshake
    in_ready_o = !flush_valid_q || flush_ready_i;
    accept     = in_valid_i && in_ready_o;
    taken      = accept && in_jump_i;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin : flush_next
    flush_valid_d = flush_valid_q;
    flush_wid_d   = flush_wid_q;
    flush_pc_d    = flush_pc_q;
    if (taken) begin
      flush_valid_d = 1'b1;
      flush_wid_d   = in_wid_i;
      flush_pc_d    = in_new_pc_i;
    end else if (flush_ready_i) begin
      flush_valid_d = 1'b0;
    end
  end

  always_comb begin : warp_decode
    start_hit = '0;
    inc_hit   = '0;
    dec_hit   = '0;
    fetch_hit = '0;
    for (int w = 0; w < NUM_WARP; w++) begin
      start_hit[w] = start_valid_i && (start_wid_i    == DEPTH_WARP'(w));
      inc_hit[w]   = br_issue_i    && (br_issue_wid_i == DEPTH_WARP'(w));
      dec_hit[w]   = accept        && (in_wid_i       == DEPTH_WARP'(w));
      fetch_hit[w] = fetch_fire_i  && (fetch_wid_i    == DEPTH_WARP'(w));
    end
  end

  // Launch beats redirect beats sequential fetch; a launch also discards any inc/dec.
  always_comb begin : warp_next
    cnt_err_d = cnt_err_q;
    for (int w = 0; w < NUM_WARP; w++) begin
      pc_d[w]  = pc_q[w];
      cnt_d[w] = cnt_q[w];

      if (start_hit[w]) begin
        pc_d[w] = start_pc_i;
      end else if (taken && dec_hit[w]) begin
        pc_d[w] = in_new_pc_i;
      end else if (fetch_hit[w]) begin
        pc_d[w] = pc_q[w] + 32'd4;
      end

      if (start_hit[w]) begin
        cnt_d[w] = '0;
      end else if (inc_hit[w] && !dec_hit[w]) begin
        if (cnt_q[w] == CNT_MAX) cnt_err_d = 1'b1;
        else                     cnt_d[w]  = cnt_q[w] + cnt_t'(1);
      end else if (dec_hit[w] && !inc_hit[w]) begin
        if (cnt_q[w] == '0) cnt_err_d = 1'b1;
        else                cnt_d[w]  = cnt_q[w] - cnt_t'(1);
      end
    end
  end

  always_comb begin : outputs
    pc_o       = '0;
    br_block_o = '0;
    for (int w = 0; w < NUM_WARP; w++) begin
      pc_o[32*w +: 32] = pc_q[w];
      br_block_o[w]    = (cnt_q[w] != '0);
    end
    flush_valid_o = flush_valid_q;
    flush_wid_o   = flush_wid_q;
    flush_pc_o    = flush_pc_q;
    cnt_err_o     = cnt_err_q;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the PC table and counters are architecturally visible after reset, so they are reset too.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WARP; w++) begin
        pc_q[w]  <= '0;
        cnt_q[w] <= '0;
      end
      flush_valid_q <= 1'b0;
      flush_wid_q   <= '0;
      flush_pc_q    <= '0;
      cnt_err_q     <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARP; w++) begin
        pc_q[w]  <= pc_d[w];
        cnt_q[w] <= cnt_d[w];
      end
      flush_valid_q <= flush_valid_d;
      flush_wid_q   <= flush_wid_d;
      flush_pc_q    <= flush_pc_d;
      cnt_err_q     <= cnt_err_d;
    end
  end

endmodule

// File: tb/tb_branch_recv_ctrl.sv
// Directed bench for branch_recv_ctrl: PC table, counters, block bits and the
// flush register under back-pressure, with hand-computed expectations.
module tb_branch_recv_ctrl;

  localparam int NUM_WARP   = 8;
  localparam int DEPTH_WARP = 3;
  localparam int CNT_W      = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start_valid_i;
  logic [DEPTH_WARP-1:0]  start_wid_i;
  logic [31:0]            start_pc_i;
  logic                   fetch_fire_i;
  logic [DEPTH_WARP-1:0]  fetch_wid_i;
  logic                   br_issue_i;
  logic [DEPTH_WARP-1:0]  br_issue_wid_i;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [DEPTH_WARP-1:0]  in_wid_i;
  logic                   in_jump_i;
  logic [31:0]            in_new_pc_i;
  logic                   flush_valid_o;
  logic                   flush_ready_i;
  logic [DEPTH_WARP-1:0]  flush_wid_o;
  logic [31:0]            flush_pc_o;
  logic [NUM_WARP*32-1:0] pc_o;
  logic [NUM_WARP-1:0]    br_block_o;
  logic                   cnt_err_o;

  int checks = 0;
  int errors = 0;

  branch_recv_ctrl #(.NUM_WARP(NUM_WARP), .DEPTH_WARP(DEPTH_WARP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .start_valid_i(start_valid_i), .start_wid_i(start_wid_i), .start_pc_i(start_pc_i),
    .fetch_fire_i(fetch_fire_i), .fetch_wid_i(fetch_wid_i),
    .br_issue_i(br_issue_i), .br_issue_wid_i(br_issue_wid_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_wid_i(in_wid_i),
    .in_jump_i(in_jump_i), .in_new_pc_i(in_new_pc_i),
    .flush_valid_o(flush_valid_o), .flush_ready_i(flush_ready_i),
    .flush_wid_o(flush_wid_o), .flush_pc_o(flush_pc_o),
    .pc_o(pc_o), .br_block_o(br_block_o), .cnt_err_o(cnt_err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pc_of(input int w);
    return pc_o[w*32 +: 32];
  endfunction

  // Inputs change 1ns after the rising edge; outputs are then stable for checking.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    start_valid_i = 1'b0; start_wid_i = '0; start_pc_i = '0;
    fetch_fire_i = 1'b0;  fetch_wid_i = '0;
    br_issue_i = 1'b0;    br_issue_wid_i = '0;
    in_valid_i = 1'b0;    in_wid_i = '0; in_jump_i = 1'b0; in_new_pc_i = '0;
  endtask

  task automatic issue(input int w);
    br_issue_i = 1'b1; br_issue_wid_i = DEPTH_WARP'(w);
    tick();
    br_issue_i = 1'b0;
  endtask

  task automatic resolve(input int w, input logic jump, input logic [31:0] pc);
    in_valid_i = 1'b1; in_wid_i = DEPTH_WARP'(w); in_jump_i = jump; in_new_pc_i = pc;
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    flush_ready_i = 1'b1;
    do_reset();
    checks++; if (flush_valid_o !== 1'b0) begin errors++; $display("FAIL reset_flush_valid got=%b exp=0", flush_valid_o); end
    checks++; if (flush_wid_o !== 3'd0 || flush_pc_o !== 32'h0) begin errors++; $display("FAIL reset_flush_data got wid=%0d pc=%h exp 0/0", flush_wid_o, flush_pc_o); end
    checks++; if (pc_o !== '0) begin errors++; $display("FAIL reset_pc_table got=%h exp=0", pc_o); end
    checks++; if (br_block_o !== 8'h00 || cnt_err_o !== 1'b0) begin errors++; $display("FAIL reset_cnt got block=%b err=%b exp 0/0", br_block_o, cnt_err_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); end
  endtask

  task automatic test_start_fetch();
    start_valid_i = 1'b1; start_wid_i = 3'd2; start_pc_i = 32'h8000_0000;
    tick();
    start_valid_i = 1'b0;
    checks++; if (pc_of(2) !== 32'h8000_0000) begin errors++; $display("FAIL start_pc got=%h exp=80000000", pc_of(2)); end
    fetch_fire_i = 1'b1; fetch_wid_i = 3'd2;
    for (int i = 0; i < 3; i++) tick();
    fetch_fire_i = 1'b0;
    checks++; if (pc_of(2) !== 32'h8000_000C) begin errors++; $display("FAIL fetch_pc got=%h exp=8000000c", pc_of(2)); end
    for (int w = 0; w < NUM_WARP; w++) begin
      if (w != 2) begin
        checks++; if (pc_of(w) !== 32'h0) begin errors++; $display("FAIL other_pc w=%0d got=%h exp=0", w, pc_of(w)); end
      end
    end
  endtask

  task automatic test_pc_wrap();
    start_valid_i = 1'b1; start_wid_i = 3'd7; start_pc_i = 32'hFFFF_FFFC;
    tick();
    start_valid_i = 1'b0;
    fetch_fire_i = 1'b1; fetch_wid_i = 3'd7;
    tick();
    fetch_fire_i = 1'b0;
    checks++; if (pc_of(7) !== 32'h0) begin errors++; $display("FAIL pc_wrap got=%h exp=0", pc_of(7)); end
  endtask

  task automatic test_taken_flush();
    issue(1);
    checks++; if (br_block_o !== 8'b0000_0010) begin errors++; $display("FAIL issue_block got=%b exp=00000010", br_block_o); end
    resolve(1, 1'b1, 32'h1000);
    checks++; if (flush_valid_o !== 1'b1 || flush_wid_o !== 3'd1 || flush_pc_o !== 32'h1000) begin
      errors++; $display("FAIL taken_flush got v=%b wid=%0d pc=%h exp 1/1/00001000", flush_valid_o, flush_wid_o, flush_pc_o); end
    checks++; if (pc_of(1) !== 32'h1000) begin errors++; $display("FAIL taken_pc got=%h exp=00001000", pc_of(1)); end
    checks++; if (br_block_o !== 8'h00) begin errors++; $display("FAIL resolve_block got=%b exp=0", br_block_o); end
    tick();
    checks++; if (flush_valid_o !== 1'b0) begin errors++; $display("FAIL flush_one_cycle got=%b exp=0", flush_valid_o); end
  endtask

  task automatic test_backpressure();
    issue(6);
    issue(6);
    flush_ready_i = 1'b0;
    resolve(6, 1'b1, 32'h2000);
    in_valid_i = 1'b1; in_wid_i = 3'd6; in_jump_i = 1'b1; in_new_pc_i = 32'h3000;
    #1;
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_low got=%b exp=0", in_ready_o); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (flush_valid_o !== 1'b1 || flush_wid_o !== 3'd6 || flush_pc_o !== 32'h2000) begin
        errors++; $display("FAIL bp_hold cyc=%0d got v=%b wid=%0d pc=%h exp 1/6/00002000", i, flush_valid_o, flush_wid_o, flush_pc_o); end
      checks++; if (pc_of(6) !== 32'h2000 || br_block_o[6] !== 1'b1) begin
        errors++; $display("FAIL bp_state cyc=%0d got pc=%h blk=%b exp 00002000/1", i, pc_of(6), br_block_o[6]); end
    end
    flush_ready_i = 1'b1;
    #1;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_high got=%b exp=1", in_ready_o); end
    tick();
    in_valid_i = 1'b0;
    checks++; if (flush_valid_o !== 1'b1 || flush_pc_o !== 32'h3000 || pc_of(6) !== 32'h3000) begin
      errors++; $display("FAIL bp_second got v=%b fpc=%h pc=%h exp 1/00003000/00003000", flush_valid_o, flush_pc_o, pc_of(6)); end
    checks++; if (br_block_o[6] !== 1'b0) begin errors++; $display("FAIL bp_block got=%b exp=0", br_block_o[6]); end
    tick();
    checks++; if (flush_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", flush_valid_o); end
  endtask

  task automatic test_same_cycle();
    start_valid_i = 1'b1; start_wid_i = 3'd3; start_pc_i = 32'h200;
    in_valid_i = 1'b1; in_wid_i = 3'd3; in_jump_i = 1'b1; in_new_pc_i = 32'h400;
    fetch_fire_i = 1'b1; fetch_wid_i = 3'd3;
    tick();
    idle();
    checks++; if (pc_of(3) !== 32'h200) begin errors++; $display("FAIL prio_pc got=%h exp=00000200", pc_of(3)); end
    checks++; if (br_block_o[3] !== 1'b0 || cnt_err_o !== 1'b0) begin errors++; $display("FAIL prio_cnt got blk=%b err=%b exp 0/0", br_block_o[3], cnt_err_o); end
    checks++; if (flush_valid_o !== 1'b1 || flush_wid_o !== 3'd3 || flush_pc_o !== 32'h400) begin
      errors++; $display("FAIL prio_flush got v=%b wid=%0d pc=%h exp 1/3/00000400", flush_valid_o, flush_wid_o, flush_pc_o); end
    tick();
  endtask

  task automatic test_not_taken();
    issue(4);
    checks++; if (br_block_o[4] !== 1'b1) begin errors++; $display("FAIL nt_block_set got=%b exp=1", br_block_o[4]); end
    resolve(4, 1'b0, 32'hDEAD_BEEF);
    checks++; if (flush_valid_o !== 1'b0) begin errors++; $display("FAIL nt_no_flush got=%b exp=0", flush_valid_o); end
    checks++; if (br_block_o[4] !== 1'b0 || pc_of(4) !== 32'h0 || cnt_err_o !== 1'b0) begin
      errors++; $display("FAIL nt_state got blk=%b pc=%h err=%b exp 0/0/0", br_block_o[4], pc_of(4), cnt_err_o); end
  endtask

  task automatic test_back_to_back();
    issue(1);
    issue(1);
    in_valid_i = 1'b1; in_wid_i = 3'd1; in_jump_i = 1'b1; in_new_pc_i = 32'h5000;
    tick();
    checks++; if (flush_valid_o !== 1'b1 || flush_pc_o !== 32'h5000) begin
      errors++; $display("FAIL b2b_first got v=%b pc=%h exp 1/00005000", flush_valid_o, flush_pc_o); end
    in_new_pc_i = 32'h6000;
    tick();
    in_valid_i = 1'b0;
    checks++; if (flush_valid_o !== 1'b1 || flush_pc_o !== 32'h6000 || pc_of(1) !== 32'h6000) begin
      errors++; $display("FAIL b2b_second got v=%b fpc=%h pc=%h exp 1/00006000/00006000", flush_valid_o, flush_pc_o, pc_of(1)); end
    checks++; if (br_block_o[1] !== 1'b0) begin errors++; $display("FAIL b2b_block got=%b exp=0", br_block_o[1]); end
    tick();
  endtask

  task automatic test_counter_errors();
    for (int i = 0; i < 3; i++) issue(0);
    checks++; if (cnt_err_o !== 1'b0) begin errors++; $display("FAIL cnt_at_max_err got=%b exp=0", cnt_err_o); end
    issue(0);
    checks++; if (cnt_err_o !== 1'b1 || br_block_o[0] !== 1'b1) begin
      errors++; $display("FAIL overflow got err=%b blk=%b exp 1/1", cnt_err_o, br_block_o[0]); end
    resolve(0, 1'b0, 32'h0);
    resolve(0, 1'b0, 32'h0);
    checks++; if (br_block_o[0] !== 1'b1) begin errors++; $display("FAIL sat_drain2 got=%b exp=1", br_block_o[0]); end
    resolve(0, 1'b0, 32'h0);
    checks++; if (br_block_o[0] !== 1'b0 || cnt_err_o !== 1'b1) begin
      errors++; $display("FAIL sat_drain3 got blk=%b err=%b exp 0/1", br_block_o[0], cnt_err_o); end
    do_reset();
    checks++; if (cnt_err_o !== 1'b0) begin errors++; $display("FAIL err_reset1 got=%b exp=0", cnt_err_o); end
    resolve(5, 1'b0, 32'h0);
    checks++; if (cnt_err_o !== 1'b1 || br_block_o[5] !== 1'b0) begin
      errors++; $display("FAIL underflow got err=%b blk=%b exp 1/0", cnt_err_o, br_block_o[5]); end
    issue(5);
    resolve(5, 1'b0, 32'h0);
    checks++; if (br_block_o[5] !== 1'b0) begin errors++; $display("FAIL underflow_held got=%b exp=0", br_block_o[5]); end
    do_reset();
    checks++; if (cnt_err_o !== 1'b0 || br_block_o !== 8'h00) begin
      errors++; $display("FAIL err_reset2 got err=%b blk=%b exp 0/0", cnt_err_o, br_block_o); end
  endtask

  task automatic test_reset_mid_flush();
    flush_ready_i = 1'b0;
    issue(2);
    resolve(2, 1'b1, 32'h7000);
    checks++; if (flush_valid_o !== 1'b1) begin errors++; $display("FAIL mid_flush_set got=%b exp=1", flush_valid_o); end
    do_reset();
    checks++; if (flush_valid_o !== 1'b0 || flush_pc_o !== 32'h0 || pc_of(2) !== 32'h0) begin
      errors++; $display("FAIL mid_flush_reset got v=%b fpc=%h pc=%h exp 0/0/0", flush_valid_o, flush_pc_o, pc_of(2)); end
    flush_ready_i = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    flush_ready_i = 1'b1;
    idle();
    test_reset();
    test_start_fetch();
    test_pc_wrap();
    test_taken_flush();
    test_backpressure();
    test_same_cycle();
    test_not_taken();
    test_back_to_back();
    test_counter_errors();
    test_reset_mid_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_recv_ctrl.md
Name: branch_recv_ctrl

Overview:
- Warp-scheduler-side consumer of resolved branch results arriving on the arbitrated branch channel (valid/ready, wid, jump, new_pc).
- Owns the per-warp PC table and per-warp in-flight-branch counters.
- Raises per-warp block bits to stop issue while branches are unresolved.
- Emits a registered, handshaked flush/redirect to fetch and ibuffer on taken branches.

Parameters:
- NUM_WARP, 8, number of warps tracked.
- DEPTH_WARP, 3, warp id width, equals log2(NUM_WARP).
- CNT_W, 2, width of each per-warp in-flight branch counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start_valid_i  input  1  warp launch; loads the PC and clears the counter for start_wid_i.
- start_wid_i  input  DEPTH_WARP  launched warp id.
- start_pc_i  input  32  launch PC.
- fetch_fire_i  input  1  fetch consumed one instruction for fetch_wid_i.
- fetch_wid_i  input  DEPTH_WARP  fetching warp id.
- br_issue_i  input  1  a branch instruction issued for br_issue_wid_i.
- br_issue_wid_i  input  DEPTH_WARP  issuing warp id.
- in_valid_i  input  1  resolved branch valid.
- in_ready_o  output  1  resolved branch accepted.
- in_wid_i  input  DEPTH_WARP  branch warp id.
- in_jump_i  input  1  branch taken.
- in_new_pc_i  input  32  target PC.
- flush_valid_o  output  1  redirect pending toward fetch/ibuffer.
- flush_ready_i  input  1  redirect consumed.
- flush_wid_o  output  DEPTH_WARP  redirected warp.
- flush_pc_o  output  32  redirect PC.
- pc_o  output  NUM_WARP*32  flattened PC table; warp w occupies bits [32w+31:32w].
- br_block_o  output  NUM_WARP  bit w is high iff counter[w] != 0.
- cnt_err_o  output  1  sticky; set on counter overflow or underflow.

Behaviour:
Reset:
- All PCs = 0 and all counters = 0.
- flush_valid_o = 0, flush_wid_o = 0, flush_pc_o = 0, cnt_err_o = 0.
- Reset mid-flush drops the pending redirect. No handshake completes in the reset cycle.

Input handshake:
- in_ready_o = !flush_valid_o || flush_ready_i. This is combinational and is independent of in_valid_i.
- Accept = in_valid_i && in_ready_o.
- Not-taken branches obey the same ready rule.

Flush register (one entry):
- On accept with in_jump_i = 1: next cycle flush_valid_o = 1, flush_wid_o = in_wid_i, flush_pc_o = in_new_pc_i.
- On flush_ready_i with no new taken accept: flush_valid_o clears next cycle.
- Simultaneous drain and new taken accept: the register reloads with the new values; valid stays 1.
- Outputs hold stable while valid && !ready.

PC table (per warp, one cycle latency, priority highest first):
1. start_valid_i: pc = start_pc_i.
2. Taken accept: pc = in_new_pc_i. The table updates in the same edge the flush register loads.
3. fetch_fire_i: pc = pc + 4, 32-bit wrap (0xFFFFFFFC + 4 = 0x00000000).
- Lower-priority events targeting the same warp in the same cycle are dropped.
- Events on different warps all apply.

Counters (per warp):
- +1 on br_issue_i.
- -1 on accept of a branch for that warp, taken or not.
- Both on the same warp in the same cycle: unchanged.
- start_valid_i on a warp forces its counter to 0 and overrides both inc and dec.
- Increment at max (2^CNT_W - 1): counter saturates and cnt_err_o sets.
- Decrement at 0: counter stays 0 and cnt_err_o sets.
- cnt_err_o clears only on rst.

br_block_o:
- Combinational from counter registers, so it is visible the cycle after issue.
- Drops the cycle after the resolving accept.

No combinational path from in_valid_i to any output.

Test Plan:
1. Reset, then start warp 2 pc=0x80000000, then 3 fetch_fire on warp 2 -> pc_o[2] = 0x8000000C; all other PCs 0.
2. br_issue on warp 1, then accept in_jump=1, new_pc=0x1000, flush_ready=1 -> br_block_o[1] goes 1 then 0; flush_valid_o high exactly 1 cycle with wid=1, pc=0x1000; pc_o[1] = 0x1000.
3. flush_ready=0 with a pending flush -> in_ready_o=0; second taken branch held; flush outputs stable 5 cycles. Raise ready -> second branch accepted the same cycle; next flush carries the second PC.
4. Same cycle on warp 3: start pc=0x200, taken branch new_pc=0x400, fetch_fire -> pc_o[3] = 0x200, counter 0, flush still emitted for warp 3.
5. Not-taken accept on warp 4 after issue -> no flush, counter 1→0, pc_o[4] unchanged.
6. With CNT_W=2: 4 issues on warp 0 -> counter 3, cnt_err_o=1. Separately, accept on warp 5 with counter 0 -> cnt_err_o=1, counter 0. Reset clears both.
